// File: rtl/pic_mode_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pic_pkg
//  Purpose  : Shared definitions for the picture-mode scheduler: display mode
//             encodings, legal key codes, default picture window geometry,
//             derived edge-image size and the key decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_RGB     = 3'd1,
        MODE_GRAY    = 3'd2,
        MODE_CAPTURE = 3'd3,
        MODE_EDGE    = 3'd4
    } mode_t;

    localparam logic [3:0] KEY_IDLE = 4'b0000;
    localparam logic [3:0] KEY_RGB  = 4'b0001;
    localparam logic [3:0] KEY_GRAY = 4'b0010;
    localparam logic [3:0] KEY_EDGE = 4'b0100;

    localparam int DEF_PIC_X0 = 500;
    localparam int DEF_PIC_Y0 = 200;
    localparam int DEF_PIC_W  = 160;
    localparam int DEF_PIC_H  = 160;
    localparam int DEF_ADDR_W = 16;

    // The Sobel stage drops a one-pixel border on every side.
    function automatic int edge_pixels(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

    localparam int EDGE_N = edge_pixels(DEF_PIC_W, DEF_PIC_H);

    typedef struct packed {
        logic  legal;
        mode_t req;
    } key_req_t;

    // Maps a key pattern to a requested mode; an edge request is reported as
    // MODE_EDGE and resolved to CAPTURE/EDGE by the scheduler.
    function automatic key_req_t key_decode(input logic [3:0] key);
        key_req_t r;
        r.legal = 1'b1;
        r.req   = MODE_IDLE;
        case (key)
            KEY_IDLE: r.req = MODE_IDLE;
            KEY_RGB:  r.req = MODE_RGB;
            KEY_GRAY: r.req = MODE_GRAY;
            KEY_EDGE: r.req = MODE_EDGE;
            default:  r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_mode_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : pic_mode_sched_if
//  Purpose  : Bundles the scheduler's control inputs (keys, frame/pixel
//             timing, Sobel valid) and its datapath control outputs.
//  Modports : master - drives keyin/frame_start/pix_x/pix_y/sobel_valid
//             slave  - the scheduler, drives mode and ROM/RAM controls
//  Revision : 1.0  initial release
// ============================================================================
interface pic_mode_sched_if #(
    parameter int ADDR_W = 16
);
    import pic_pkg::*;

    logic [3:0]        keyin;
    logic              frame_start;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              sobel_valid;

    mode_t             mode;
    logic              rom_rden;
    logic [ADDR_W-1:0] rom_addr;
    logic              ram_wren;
    logic              ram_rden;
    logic [ADDR_W-1:0] ram_addr;
    logic              edge_ready;
    logic              cap_err;

    modport master (
        output keyin, frame_start, pix_x, pix_y, sobel_valid,
        input  mode, rom_rden, rom_addr, ram_wren, ram_rden, ram_addr,
               edge_ready, cap_err
    );

    modport slave (
        input  keyin, frame_start, pix_x, pix_y, sobel_valid,
        output mode, rom_rden, rom_addr, ram_wren, ram_rden, ram_addr,
               edge_ready, cap_err
    );

endinterface
`default_nettype wire

// File: rtl/pic_mode_sched_win_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pic_win_cnt
//  Purpose  : Registered rectangular window test plus an enable-gated read
//             address counter that clears on frame_start and wraps at LAST.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             en            - mode gate for the read enable
//             frame_start   - clears the address counter
//             pix_x, pix_y  - current pixel position
//             rden          - window hit from the previous pixel, gated by en
//             addr          - address belonging to the current rden cycle
//  Revision : 1.0  initial release
// ============================================================================
module pic_win_cnt #(
    parameter int X_MIN  = 500,
    parameter int X_MAX  = 659,
    parameter int Y_MIN  = 200,
    parameter int Y_MAX  = 359,
    parameter int ADDR_W = 16,
    parameter int LAST   = 25599
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic              frame_start,
    input  wire logic [9:0]        pix_x,
    input  wire logic [9:0]        pix_y,
    output logic                   rden,
    output logic [ADDR_W-1:0]      addr
);

    localparam logic [9:0]        C_X_LO = 10'(X_MIN);
    localparam logic [9:0]        C_X_HI = 10'(X_MAX);
    localparam logic [9:0]        C_Y_LO = 10'(Y_MIN);
    localparam logic [9:0]        C_Y_HI = 10'(Y_MAX);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(LAST);

    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        win_d = (pix_x >= C_X_LO) && (pix_x <= C_X_HI) &&
                (pix_y >= C_Y_LO) && (pix_y <= C_Y_HI);

        rden   = en & win_q;

        // frame_start wins over a coincident read so each frame starts at 0.
        addr_d = addr_q;
        if (frame_start) begin
            addr_d = '0;
        end else if (rden) begin
            addr_d = (addr_q == C_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            win_q  <= win_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/pic_mode_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pic_mode_sched
//  Purpose  : Display-mode scheduler for the picture datapath. Latches key
//             requests, switches mode on frame boundaries, runs a one-frame
//             Sobel capture into the edge RAM before edge display, and drives
//             the ROM/RAM enables and addresses for the picture window.
//  Ports    : clk  - system clock
//             rst  - asynchronous reset, active-high
//             sif  - slave side of pic_mode_sched_if (keys, pixel timing,
//                    Sobel valid in; mode, ROM/RAM controls, status out)
//  Revision : 1.0  initial release
// ============================================================================
module pic_mode_sched
    import pic_pkg::*;
#(
    parameter int PIC_X0 = DEF_PIC_X0,
    parameter int PIC_Y0 = DEF_PIC_Y0,
    parameter int PIC_W  = DEF_PIC_W,
    parameter int PIC_H  = DEF_PIC_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pic_mode_sched_if.slave    sif
);

    localparam int              C_EDGE_CNT  = edge_pixels(PIC_W, PIC_H);
    localparam logic [ADDR_W-1:0] C_EDGE_LAST = ADDR_W'(C_EDGE_CNT - 1);

    mode_t             mode_q, mode_d;
    mode_t             pend_q, pend_d;
    logic              edge_ready_q, edge_ready_d;
    logic              cap_err_q, cap_err_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;

    key_req_t          w_key;
    logic              w_wr_fire;
    logic              w_wr_last;
    mode_t             w_target;
    logic              w_rom_en;
    logic              w_ram_en;
    logic              w_ram_rden;
    logic [ADDR_W-1:0] w_rd_addr;

    always_comb begin
        w_key  = key_decode(sif.keyin);
        pend_d = w_key.legal ? w_key.req : pend_q;

        // In CAPTURE edge_ready doubles as the "capture complete" flag, so
        // writes stop as soon as the last edge pixel has been stored.
        w_wr_fire = (mode_q == MODE_CAPTURE) && !edge_ready_q && sif.sobel_valid;
        w_wr_last = w_wr_fire && (wr_cnt_q == C_EDGE_LAST);

        // An edge request needs a complete image; otherwise capture first.
        w_target = ((pend_q == MODE_EDGE) && !edge_ready_q) ? MODE_CAPTURE : pend_q;

        mode_d       = mode_q;
        edge_ready_d = edge_ready_q;
        cap_err_d    = cap_err_q;
        wr_cnt_d     = wr_cnt_q;

        if (w_wr_fire) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            if (w_wr_last) begin
                edge_ready_d = 1'b1;
            end
        end

        if (sif.frame_start) begin
            if (mode_q == MODE_CAPTURE) begin
                if (edge_ready_q) begin
                    mode_d = w_target;
                end else if (!w_wr_last) begin
                    // A whole frame passed without a full edge image.
                    cap_err_d = 1'b1;
                    mode_d    = MODE_IDLE;
                end
                // A final write coinciding with frame_start keeps CAPTURE for
                // one more frame; the switch happens at the next boundary.
            end else begin
                mode_d = w_target;
                if (w_target == MODE_CAPTURE) begin
                    wr_cnt_d     = '0;
                    edge_ready_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_IDLE;
            pend_q       <= MODE_IDLE;
            edge_ready_q <= 1'b0;
            cap_err_q    <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            edge_ready_q <= edge_ready_d;
            cap_err_q    <= cap_err_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign w_rom_en = (mode_q == MODE_RGB) || (mode_q == MODE_GRAY) ||
                      (mode_q == MODE_CAPTURE);
    assign w_ram_en = (mode_q == MODE_EDGE);

    pic_win_cnt #(
        .X_MIN  (PIC_X0),
        .X_MAX  (PIC_X0 + PIC_W - 1),
        .Y_MIN  (PIC_Y0),
        .Y_MAX  (PIC_Y0 + PIC_H - 1),
        .ADDR_W (ADDR_W),
        .LAST   (PIC_W * PIC_H - 1)
    ) u_rom_win (
        .clk         (clk),
        .rst         (rst),
        .en          (w_rom_en),
        .frame_start (sif.frame_start),
        .pix_x       (sif.pix_x),
        .pix_y       (sif.pix_y),
        .rden        (sif.rom_rden),
        .addr        (sif.rom_addr)
    );

    // The edge image is two pixels narrower and shorter than the picture.
    pic_win_cnt #(
        .X_MIN  (PIC_X0),
        .X_MAX  (PIC_X0 + PIC_W - 3),
        .Y_MIN  (PIC_Y0),
        .Y_MAX  (PIC_Y0 + PIC_H - 3),
        .ADDR_W (ADDR_W),
        .LAST   (C_EDGE_CNT - 1)
    ) u_ram_win (
        .clk         (clk),
        .rst         (rst),
        .en          (w_ram_en),
        .frame_start (sif.frame_start),
        .pix_x       (sif.pix_x),
        .pix_y       (sif.pix_y),
        .rden        (w_ram_rden),
        .addr        (w_rd_addr)
    );

    // Single RAM port: the mode decides who owns the address, so a write and
    // a read can never be issued in the same cycle.
    assign sif.ram_rden   = w_ram_rden;
    assign sif.ram_wren   = w_wr_fire;
    assign sif.ram_addr   = (mode_q == MODE_CAPTURE) ? wr_cnt_q  :
                            (mode_q == MODE_EDGE)    ? w_rd_addr : '0;
    assign sif.mode       = mode_q;
    assign sif.edge_ready = edge_ready_q;
    assign sif.cap_err    = cap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_mode_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_mode_sched
//  Purpose  : Randomized self-checking bench for pic_mode_sched. A driver
//             issues one stimulus per cycle and queues the response predicted
//             by a behavioural model; a monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pic_mode_sched;
    import pic_pkg::*;

    localparam int X0 = 500;
    localparam int Y0 = 200;
    localparam int W  = 160;
    localparam int H  = 160;
    localparam int EN = (W - 2) * (H - 2);
    localparam int RN = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pic_mode_sched_if #(.ADDR_W(16)) sif ();

    pic_mode_sched #(
        .PIC_X0 (X0),
        .PIC_Y0 (Y0),
        .PIC_W  (W),
        .PIC_H  (H),
        .ADDR_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        int mode;
        int rom_rden;
        int rom_addr;
        int ram_wren;
        int ram_rden;
        int ram_addr;
        int edge_ready;
        int cap_err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state: display mode, requested mode, image status,
    // pixels written this capture, per-frame read positions, last-pixel hits.
    int   m_mode, m_pend, m_ready, m_err, m_wr, m_rom, m_rd, m_prev_rom, m_prev_ram;

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_ready = 0; m_err = 0; m_wr = 0;
        m_rom = 0; m_rd = 0; m_prev_rom = 0; m_prev_ram = 0;
    endtask

    function automatic int rn(input int lo, input int hi);
        return lo + int'($urandom % (hi - lo + 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the predicted outputs for this cycle are
    // queued and the model then advances across the coming clock edge.
    task automatic step(input logic r, input logic [3:0] k, input logic fs,
                        input int px, input int py, input logic sv);
        exp_t e;
        int   nm, tgt;
        @(posedge clk);
        #1;
        rst             = r;
        sif.keyin       = k;
        sif.frame_start = fs;
        sif.pix_x       = 10'(px);
        sif.pix_y       = 10'(py);
        sif.sobel_valid = sv;
        if (r) begin
            model_reset();
            e = '{default: 0};
            q.push_back(e);
            return;
        end
        e.mode       = m_mode;
        e.rom_rden   = ((m_mode >= 1 && m_mode <= 3) && m_prev_rom != 0) ? 1 : 0;
        e.rom_addr   = m_rom;
        e.ram_rden   = (m_mode == 4 && m_prev_ram != 0) ? 1 : 0;
        e.ram_wren   = (m_mode == 3 && m_wr < EN && sv) ? 1 : 0;
        e.ram_addr   = (m_mode == 3) ? m_wr : (m_mode == 4) ? m_rd : 0;
        e.edge_ready = m_ready;
        e.cap_err    = m_err;
        q.push_back(e);

        tgt = (m_pend == 4) ? (m_ready ? 4 : 3) : m_pend;
        nm  = m_mode;
        if (fs) begin
            if (m_mode == 3) begin
                if (m_wr == EN) nm = tgt;
                else if (!(e.ram_wren == 1 && m_wr == EN - 1)) begin
                    nm = 0;
                    m_err = 1;
                end
            end else begin
                nm = tgt;
            end
        end
        if (e.ram_wren == 1) begin
            m_wr++;
            if (m_wr == EN) m_ready = 1;
        end
        if (fs) m_rom = 0; else if (e.rom_rden == 1) m_rom = (m_rom + 1) % RN;
        if (fs) m_rd  = 0; else if (e.ram_rden == 1) m_rd  = (m_rd + 1) % EN;
        if (nm == 3 && m_mode != 3) begin
            m_wr    = 0;
            m_ready = 0;
        end
        m_mode = nm;
        case (k)
            4'b0000: m_pend = 0;
            4'b0001: m_pend = 1;
            4'b0010: m_pend = 2;
            4'b0100: m_pend = 4;
            default: ;
        endcase
        m_prev_rom = (px >= X0 && px <= X0 + W - 1 && py >= Y0 && py <= Y0 + H - 1) ? 1 : 0;
        m_prev_ram = (px >= X0 && px <= X0 + W - 3 && py >= Y0 && py <= Y0 + H - 3) ? 1 : 0;
    endtask

    task automatic near_cycles(input int n, input logic [3:0] k, input logic sv_rand);
        for (int i = 0; i < n; i++)
            step(1'b0, k, 1'b0, rn(X0 - 8, X0 + W + 8), rn(Y0 - 8, Y0 + H + 8),
                 sv_rand ? 1'($urandom % 2) : 1'b0);
    endtask

    // Monitor: compares every presented output set against the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mode",       int'(sif.mode),   e.mode);
                chk("rom_rden",   int'(sif.rom_rden), e.rom_rden);
                chk("rom_addr",   int'(sif.rom_addr), e.rom_addr);
                chk("ram_wren",   int'(sif.ram_wren), e.ram_wren);
                chk("ram_rden",   int'(sif.ram_rden), e.ram_rden);
                chk("ram_addr",   int'(sif.ram_addr), e.ram_addr);
                chk("edge_ready", int'(sif.edge_ready), e.edge_ready);
                chk("cap_err",    int'(sif.cap_err), e.cap_err);
            end
        end
    end

    initial begin : driver
        int   idx;
        logic sv;
        sif.keyin = 4'b0000; sif.frame_start = 1'b0;
        sif.pix_x = '0; sif.pix_y = '0; sif.sobel_valid = 1'b0;
        model_reset();

        repeat (3) step(1'b1, 4'b0000, 1'b0, 0, 0, 1'b0);
        near_cycles(20, 4'b0000, 1'b1);

        // RGB request: no change until the frame boundary.
        near_cycles(5, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b1, 0, 0, 1'b0);
        step(1'b0, 4'b0001, 1'b0, X0, Y0, 1'b0);
        step(1'b0, 4'b0001, 1'b0, X0 - 1, Y0, 1'b0);
        step(1'b0, 4'b0001, 1'b0, X0, Y0 - 1, 1'b0);
        step(1'b0, 4'b0001, 1'b0, X0 + W - 1, Y0 + H - 1, 1'b0);
        step(1'b0, 4'b0001, 1'b0, X0 + W, Y0 + H - 1, 1'b0);
        near_cycles(300, 4'b0001, 1'b1);

        // Edge request without an image: full-window capture frame; the key
        // switches to gray midway and must only take effect afterwards.
        near_cycles(4, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        idx = 0;
        for (int y = Y0; y < Y0 + H; y++) begin
            for (int x = X0; x < X0 + W; x++) begin
                sv = (idx < 600) ? 1'($urandom % 2) : 1'b1;
                step(1'b0, (idx >= 12000) ? 4'b0010 : 4'b0100, 1'b0, x, y, sv);
                idx++;
            end
        end
        step(1'b0, 4'b0010, 1'b0, 0, 0, 1'b1);
        step(1'b0, 4'b0010, 1'b1, 0, 0, 1'b0);
        near_cycles(200, 4'b0010, 1'b1);

        // Edge display from the stored image; writes must stay off.
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b1);
        step(1'b0, 4'b0100, 1'b0, X0 + W - 3, Y0 + H - 3, 1'b1);
        step(1'b0, 4'b0100, 1'b0, X0 + W - 2, Y0 + H - 3, 1'b1);
        step(1'b0, 4'b0100, 1'b0, X0 + W - 3, Y0 + H - 2, 1'b1);
        near_cycles(3000, 4'b0100, 1'b1);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        near_cycles(20, 4'b0100, 1'b1);

        // Reset in the middle of a capture.
        repeat (2) step(1'b1, 4'b0000, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 5000; i++)
            step(1'b0, 4'b0100, 1'b0, rn(0, 1023), rn(0, 1023), 1'b1);
        repeat (2) step(1'b1, 4'b0100, 1'b0, 0, 0, 1'b1);
        step(1'b0, 4'b0000, 1'b0, X0, Y0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, X0, Y0, 1'b0);

        // Starved capture: too few Sobel pixels before the next boundary.
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 4'b0100, 1'b0, X0 + i, Y0, 1'b1);
            step(1'b0, 4'b0100, 1'b0, X0 + i, Y0, 1'b0);
        end
        step(1'b0, 4'b0000, 1'b1, 0, 0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 0, 0, 1'b0);
        step(1'b0, 4'b0110, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0110, 1'b1, 0, 0, 1'b0);
        near_cycles(10, 4'b0110, 1'b0);

        // Final write coinciding with frame_start.
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < EN - 1; i++)
            step(1'b0, 4'b0100, 1'b0, rn(X0 - 4, X0 + W + 4), rn(Y0 - 4, Y0 + H + 4), 1'b1);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 0, 0, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 0, 0, 1'b0);
        near_cycles(50, 4'b0100, 1'b1);

        // Random keys, boundaries and Sobel activity.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] kk;
            case ($urandom % 7)
                0: kk = 4'b0000; 1: kk = 4'b0001; 2: kk = 4'b0010;
                3: kk = 4'b0100; 4: kk = 4'b0110; 5: kk = 4'b1000;
                default: kk = 4'b0011;
            endcase
            step(1'b0, kk, 1'(($urandom % 150) == 0), rn(X0 - 6, X0 + W + 6),
                 rn(Y0 - 6, Y0 + H + 6), 1'($urandom % 2));
        end

        step(1'b0, 4'b0000, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_mode_sched.md
Name: pic_mode_sched

Overview:
- Sequences the picture datapath: picture ROM, grayscale stage, Sobel stage and the single-port edge RAM.
- Latches the key-selected display mode and applies it only at frame boundaries.
- Generates the ROM/RAM enables and addresses for the picture window.
- Runs a one-frame Sobel capture into RAM before edge display is allowed, and owns the RAM port so write and read never collide.

Parameters:
- PIC_X0, 500, window left column
- PIC_Y0, 200, window top row
- PIC_W, 160, picture width
- PIC_H, 160, picture height
- ADDR_W, 16, ROM/RAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- keyin  in  4  mode request: 0000 idle, 0001 rgb, 0010 gray, 0100 edge; any other value ignored
- frame_start  in  1  one-cycle pulse at start of each frame
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- sobel_valid  in  1  Sobel output pixel valid
- mode  out  3  active mode: 0 IDLE, 1 RGB, 2 GRAY, 3 CAPTURE, 4 EDGE
- rom_rden  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM address
- ram_wren  out  1  edge RAM write enable
- ram_rden  out  1  edge RAM read enable
- ram_addr  out  ADDR_W  shared RAM address
- edge_ready  out  1  RAM holds a complete edge image
- cap_err  out  1  sticky: capture incomplete

Behaviour:
- Reset values: all outputs 0, mode=IDLE, pending request=IDLE, internal counters 0.
- Key latch:
  - A legal keyin different from the current pending value is registered as the pending request.
  - Illegal patterns leave the pending request unchanged.
- Transitions (taken only on frame_start, except the CAPTURE completion rule below):
  - IDLE/RGB/GRAY/EDGE -> pending mode.
  - A pending edge request goes to EDGE if edge_ready=1, else to CAPTURE.
  - CAPTURE is not interruptible by keys. The pending request is re-latched and applied on the first frame_start after the capture completes.
  - Once wr_cnt reaches EDGE_N, CAPTURE -> EDGE at the next frame_start.
  - If CAPTURE sees a second frame_start without completion: set cap_err and go to IDLE. cap_err clears only on rst.
- Window tests are registered, giving 1-cycle latency from pix_x/pix_y.
- rom_rden:
  - 1 in RGB/GRAY/CAPTURE when PIC_X0<=pix_x<=PIC_X0+PIC_W-1 and PIC_Y0<=pix_y<=PIC_Y0+PIC_H-1.
  - rom_addr increments on each rom_rden cycle and clears on frame_start.
  - Wraps PIC_W*PIC_H-1 -> 0 (25599 -> 0).
- Edge image: EDGE_N=(PIC_W-2)*(PIC_H-2)=24964 pixels.
- CAPTURE:
  - ram_wren = sobel_valid.
  - Write counter starts at 0 on CAPTURE entry and increments per write.
  - At EDGE_N-1 the final write sets edge_ready=1 and completes the capture. Further sobel_valid pulses in the same state are ignored (ram_wren=0).
- EDGE:
  - ram_rden=1 when PIC_X0<=pix_x<=PIC_X0+PIC_W-3 and PIC_Y0<=pix_y<=PIC_Y0+PIC_H-3, window registered as above.
  - The read counter increments per ram_rden, clears on frame_start, and wraps at EDGE_N-1.
- RAM arbitration:
  - ram_addr = write counter in CAPTURE, read counter in EDGE, 0 otherwise.
  - ram_wren and ram_rden are never both 1.
  - rom_rden is 0 in IDLE and EDGE.
- edge_ready clears on entry to CAPTURE and on rst.
- Reset mid-capture: immediate return to reset values; the partial RAM contents are considered invalid (edge_ready=0).
- Simultaneous frame_start and final write: the write completes first. The state stays CAPTURE this frame and moves to EDGE at the next frame_start.

Decomposition:
- Shared package pic_pkg holds:
  - mode encodings (IDLE..EDGE)
  - legal key codes
  - default window constants
  - EDGE_N as a derived constant
- One natural sub-module: pic_win_cnt. It performs the registered window test and the enable-gated address counter with frame_start clear and a wrap limit. It is instantiated twice, once for ROM (full window) and once for RAM read (reduced window).
- The FSM and write counter remain in the top level.

Test Plan:
- Reset then keyin=0001 with frame_start:
  - Before frame_start, mode stays 0.
  - After frame_start, mode=1.
  - At pix=(500,200), rom_rden=1 one cycle later.
  - rom_addr reaches 25599 at pix (659,359), then wraps to 0 on frame_start.
- keyin=0100 with edge_ready=0:
  - mode goes to 3 at frame_start.
  - Drive 24964 sobel_valid pulses: ram_addr goes 0..24963 and ram_wren pulses 24964 times.
  - edge_ready rises after the last write; the next frame_start gives mode=4.
- EDGE display: ram_rden=1 only for pix_x 500..657 and pix_y 200..357, and ram_wren stays 0 throughout.
- keyin changes to 0010 mid-CAPTURE: mode stays 3 until the capture completes, then goes to 2 at the following frame_start.
- Capture starved (only 100 sobel_valid pulses before the second frame_start): cap_err=1, mode=0, edge_ready=0.
- rst asserted mid-capture at write 5000, then released:
  - All outputs are 0.
  - A subsequent edge request re-enters CAPTURE with ram_addr starting at 0.
  - An illegal keyin=0110 leaves mode unchanged.
